// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: next-PC select codes and default parameter values.
// The return-address stack is built only when PC_SEQUENCER_RAS_EN is defined.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_BR,
        SEL_JMP,
        SEL_RET
    } next_sel_t;

    localparam int DEF_PC_WIDTH  = 13;
    localparam int DEF_PC_INC    = 1;
    localparam int DEF_RESET_VEC = 0;
    localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer addressed by a write pointer, with an occupancy count.
// A push onto a full stack overwrites the oldest entry; a pop from an empty stack only flags an error.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = DEF_PC_WIDTH,
    parameter int DEPTH = DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign top   = mem[wr_ptr - PTR_W'(1)];

    // Entry storage carries no reset; contents are invisible while the count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            err <= (push && full) || (pop && empty);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (!full) begin
                    count <= count + CNT_W'(1);
                end
            end else if (pop && !empty) begin
                wr_ptr <= wr_ptr - PTR_W'(1);
                count  <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with increment, relative branch, absolute jump, call and return.
// Define PC_SEQUENCER_RAS_EN to build the return-address stack; otherwise call is a plain jump.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int PC_WIDTH  = DEF_PC_WIDTH,
    parameter int PC_INC    = DEF_PC_INC,
    parameter int RESET_VEC = DEF_RESET_VEC,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_en,
    input  logic [PC_WIDTH-1:0] branch_off,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                call_en,
    input  logic                ret_en,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_err
);

    next_sel_t           sel;
    logic [PC_WIDTH-1:0] ras_top;

    assign pc_plus = pc + PC_WIDTH'(PC_INC);

`ifdef PC_SEQUENCER_RAS_EN
    logic ras_push;
    logic ras_pop;

    pc_ras #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .err       (ras_err)
    );

    // A return on an empty stack still requests a pop so the stack can flag the underflow.
    always_comb begin
        sel      = SEL_INC;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (ret_en) begin
            ras_pop = 1'b1;
            sel     = ras_empty ? SEL_INC : SEL_RET;
        end else if (call_en) begin
            ras_push = 1'b1;
            sel      = SEL_JMP;
        end else if (jump_en) begin
            sel = SEL_JMP;
        end else if (branch_en) begin
            sel = SEL_BR;
        end
    end
`else
    logic unused_ret;

    assign unused_ret = ret_en;
    assign ras_top    = pc_plus;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_err    = 1'b0;

    always_comb begin
        sel = SEL_INC;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (call_en || jump_en) begin
            sel = SEL_JMP;
        end else if (branch_en) begin
            sel = SEL_BR;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= PC_WIDTH'(RESET_VEC);
        end else begin
            case (sel)
                SEL_HOLD: pc <= pc;
                SEL_BR:   pc <= pc_plus + branch_off;
                SEL_JMP:  pc <= jump_target;
                SEL_RET:  pc <= ras_top;
                default:  pc <= pc_plus;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven vectors fed through an expected-value queue.
// Exercises the return-address stack when PC_SEQUENCER_RAS_EN is defined, the plain-jump build otherwise.
module tb_pc_sequencer;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          branch_en;
        logic [12:0] branch_off;
        bit          jump_en;
        logic [12:0] jump_target;
        bit          call_en;
        bit          ret_en;
        logic [12:0] exp_pc;
        bit          exp_empty;
        bit          exp_full;
        bit          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_en;
    logic [12:0] branch_off;
    logic        jump_en;
    logic [12:0] jump_target;
    logic        call_en;
    logic        ret_en;
    logic [12:0] pc;
    logic [12:0] pc_plus;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   vec_idx = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_en   (branch_en),
        .branch_off  (branch_off),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full),
        .ras_err     (ras_err)
    );

    function automatic vec_t mk(bit r, bit st, bit br, logic [12:0] off, bit jmp,
                                logic [12:0] tgt, bit call, bit ret, logic [12:0] epc,
                                bit eempty, bit efull, bit eerr);
        vec_t v;
        v.rst = r;           v.stall = st;       v.branch_en = br;  v.branch_off = off;
        v.jump_en = jmp;     v.jump_target = tgt; v.call_en = call; v.ret_en = ret;
        v.exp_pc = epc;      v.exp_empty = eempty; v.exp_full = efull; v.exp_err = eerr;
        return v;
    endfunction

    // Shorthands: idle step, jump, call, return, each with the expected state after the edge.
    function automatic vec_t idle(logic [12:0] epc, bit e, bit f, bit er);
        return mk(0, 0, 0, 13'h0, 0, 13'h0, 0, 0, epc, e, f, er);
    endfunction
    function automatic vec_t jmp(logic [12:0] t, logic [12:0] epc, bit e, bit f, bit er);
        return mk(0, 0, 0, 13'h0, 1, t, 0, 0, epc, e, f, er);
    endfunction
    function automatic vec_t call(logic [12:0] t, logic [12:0] epc, bit e, bit f, bit er);
        return mk(0, 0, 0, 13'h0, 0, t, 1, 0, epc, e, f, er);
    endfunction
    function automatic vec_t ret(logic [12:0] epc, bit e, bit f, bit er);
        return mk(0, 0, 0, 13'h0, 0, 13'h0, 0, 1, epc, e, f, er);
    endfunction

    task automatic compare(string name, logic [12:0] act, logic [12:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("[TB] FAIL vec%0d %s: got 0x%04h, expected 0x%04h", vec_idx, name, act, req);
        end
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL vec%0d scoreboard: got empty queue, expected a pending record", vec_idx);
            return;
        end
        e = exp_q.pop_front();
        compare("pc", pc, e.exp_pc);
        compare("pc_plus", pc_plus, e.exp_pc + 13'd1);
        compare("ras_empty", {12'h0, ras_empty}, {12'h0, e.exp_empty});
        compare("ras_full", {12'h0, ras_full}, {12'h0, e.exp_full});
        compare("ras_err", {12'h0, ras_err}, {12'h0, e.exp_err});
    endtask

    task automatic applyStimulus(vec_t v);
        @(negedge clk);
        rst         = v.rst;
        stall       = v.stall;
        branch_en   = v.branch_en;
        branch_off  = v.branch_off;
        jump_en     = v.jump_en;
        jump_target = v.jump_target;
        call_en     = v.call_en;
        ret_en      = v.ret_en;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
        vec_idx++;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_off = '0;
        jump_en = 1'b0; jump_target = '0; call_en = 1'b0; ret_en = 1'b0;

        // Reset, idle count, branch arithmetic and wrap, jump priority.
        tbl.push_back(mk(1, 0, 0, 13'h0, 0, 13'h0, 0, 0, 13'h0000, 1, 0, 0));
        tbl.push_back(idle(13'h0001, 1, 0, 0));
        tbl.push_back(idle(13'h0002, 1, 0, 0));
        tbl.push_back(idle(13'h0003, 1, 0, 0));
        tbl.push_back(jmp(13'h0010, 13'h0010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 13'h1FFC, 0, 13'h0, 0, 0, 13'h000D, 1, 0, 0));
        tbl.push_back(jmp(13'h1FFF, 13'h1FFF, 1, 0, 0));
        tbl.push_back(idle(13'h0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 13'h0005, 1, 13'h0100, 0, 0, 13'h0100, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 13'h0, 1, 13'h0055, 0, 0, 13'h0100, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 13'h0007, 0, 13'h0, 0, 0, 13'h0100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 13'h0010, 0, 13'h0, 0, 0, 13'h0111, 1, 0, 0));
        tbl.push_back(jmp(13'h1FFE, 13'h1FFE, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 13'h0003, 0, 13'h0, 0, 0, 13'h0002, 1, 0, 0));
        tbl.push_back(jmp(13'h0020, 13'h0020, 1, 0, 0));
`ifdef PC_SEQUENCER_RAS_EN
        // Single call/return, then overflow with five calls and underflow on the fifth return.
        tbl.push_back(call(13'h0400, 13'h0400, 0, 0, 0));
        tbl.push_back(ret(13'h0021, 1, 0, 0));
        tbl.push_back(call(13'h0100, 13'h0100, 0, 0, 0));
        tbl.push_back(call(13'h0200, 13'h0200, 0, 0, 0));
        tbl.push_back(call(13'h0300, 13'h0300, 0, 0, 0));
        tbl.push_back(call(13'h0400, 13'h0400, 0, 1, 0));
        tbl.push_back(call(13'h0500, 13'h0500, 0, 1, 1));
        tbl.push_back(ret(13'h0401, 0, 0, 0));
        tbl.push_back(ret(13'h0301, 0, 0, 0));
        tbl.push_back(ret(13'h0201, 0, 0, 0));
        tbl.push_back(ret(13'h0101, 1, 0, 0));
        tbl.push_back(ret(13'h0102, 1, 0, 1));
        tbl.push_back(idle(13'h0103, 1, 0, 0));
        // Return and call together: the return wins and nothing is pushed.
        tbl.push_back(call(13'h0600, 13'h0600, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 13'h0, 0, 13'h0700, 1, 1, 13'h0104, 1, 0, 0));
        tbl.push_back(idle(13'h0105, 1, 0, 0));
        // A stalled return leaves the stack intact.
        tbl.push_back(call(13'h0050, 13'h0050, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 13'h0, 0, 13'h0, 0, 1, 13'h0050, 0, 0, 0));
        tbl.push_back(ret(13'h0106, 1, 0, 0));
        // Reset during a stalled call: stack cleared, a following return underflows.
        tbl.push_back(call(13'h0080, 13'h0080, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 13'h0, 0, 13'h0900, 1, 0, 13'h0000, 1, 0, 0));
        tbl.push_back(ret(13'h0001, 1, 0, 1));
        tbl.push_back(idle(13'h0002, 1, 0, 0));
`else
        // Without the stack, call is a plain jump and return is a plain increment.
        tbl.push_back(call(13'h0400, 13'h0400, 1, 0, 0));
        tbl.push_back(ret(13'h0401, 1, 0, 0));
        tbl.push_back(ret(13'h0402, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 13'h0, 0, 13'h0900, 1, 0, 13'h0000, 1, 0, 0));
        tbl.push_back(idle(13'h0001, 1, 0, 0));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
        end

        // Long stall with random control inputs: pc must not move.
        v = jmp(13'h0333, 13'h0333, 1, 0, 0);
`ifdef PC_SEQUENCER_RAS_EN
        v.exp_empty = ras_empty;
`endif
        applyStimulus(v);
        for (int i = 0; i < 6; i++) begin
            v = mk(0, 1, 1'($urandom), 13'($urandom), 1'($urandom), 13'($urandom),
                   1'($urandom), 1'($urandom), 13'h0333, 1, 0, 0);
            applyStimulus(v);
        end

        // Reset held for several cycles against active controls, then normal counting resumes.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(1, 0, 1, 13'h0004, 1, 13'h0777, 1, 1, 13'h0000, 1, 0, 0));
        end
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(idle(13'(i), 1, 0, 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
